// File: rtl/alu_bist_driver_if.sv
// alu_bist_driver_if: stimulus/response bus between the BIST driver and the ALU under test.
//   master (BIST driver): drives ALUops, READ_Reg_1, READ_Data_2; samples ALU_Output, Branch_Output
//   slave  (ALU side)   : receives opcode/operands; returns ALU_Output, Branch_Output
interface alu_bist_driver_if;
    logic [3:0]  ALUops;
    logic [31:0] READ_Reg_1;
    logic [31:0] READ_Data_2;
    logic [31:0] ALU_Output;
    logic        Branch_Output;
    modport master (output ALUops, READ_Reg_1, READ_Data_2, input ALU_Output, Branch_Output);
    modport slave  (input ALUops, READ_Reg_1, READ_Data_2, output ALU_Output, Branch_Output);
endinterface

// File: rtl/alu_bist_driver.sv
// alu_bist_driver: BIST initiator for the single-cycle ALU; LFSR operands over every opcode, MISR compaction, golden compare.
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   start      : start pulse, honoured only in IDLE and DONE
//   busy       : high while the run is in progress
//   done       : high once the run has finished, held until the next start
//   pass       : valid with done; signature matched GOLDEN_SIG
//   signature  : current MISR value
//   alu        : master side of the ALU bus (opcode/operands out, result/branch in)
// Optional feature macro ALU_BIST_CORNER_EN: vectors 0..3 of each opcode use fixed corner
// operand pairs and the LFSRs restart from the seed for every opcode.
module alu_bist_driver #(
    parameter int          NUM_OPS        = 16,
    parameter int          VECTORS_PER_OP = 16,
    parameter logic [31:0] LFSR_SEED      = 32'hACE12345,
    parameter logic [31:0] GOLDEN_SIG     = 32'h00000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature,
    alu_bist_driver_if.master alu
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED_A   = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [31:0] SEED_B   = (~LFSR_SEED == 32'd0) ? 32'd1 : ~LFSR_SEED;
    localparam logic [4:0]  LAST_OP  = 5'(NUM_OPS - 1);
    localparam logic [15:0] LAST_VEC = 16'(VECTORS_PER_OP - 1);
`ifdef ALU_BIST_CORNER_EN
    localparam logic [31:0] START_A  = 32'h0;
    localparam logic [31:0] START_B  = 32'h0;
`else
    localparam logic [31:0] START_A  = SEED_A;
    localparam logic [31:0] START_B  = SEED_B;
`endif

    state_t      state;
    logic [31:0] lfsr_a, lfsr_b, misr;
    logic [4:0]  op, op_nx;
    logic [15:0] vec, vec_nx;
    logic [31:0] d, misr_nx, lfsr_a_nx, lfsr_b_nx, a_nx, b_nx;
    logic        last;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    assign signature = misr;

    always_comb begin
        d         = alu.ALU_Output ^ {31'b0, alu.Branch_Output};
        misr_nx   = {misr[30:0], 1'b0} ^ (misr[31] ? 32'h04C11DB7 : 32'h0) ^ d;
        last      = (op == LAST_OP) && (vec == LAST_VEC);
        vec_nx    = (vec == LAST_VEC) ? 16'd0 : vec + 16'd1;
        op_nx     = (vec == LAST_VEC) ? op + 5'd1 : op;
`ifdef ALU_BIST_CORNER_EN
        // LFSRs hold through the corner vectors and restart from the seed at each new opcode.
        lfsr_a_nx = (vec == LAST_VEC) ? SEED_A : (vec < 16'd4) ? lfsr_a : lfsr_step(lfsr_a);
        lfsr_b_nx = (vec == LAST_VEC) ? SEED_B : (vec < 16'd4) ? lfsr_b : lfsr_step(lfsr_b);
        a_nx      = (vec_nx == 16'd0) ? 32'h00000000 :
                    (vec_nx == 16'd1) ? 32'hFFFFFFFF :
                    (vec_nx == 16'd2) ? 32'h80000000 :
                    (vec_nx == 16'd3) ? 32'h7FFFFFFF : lfsr_a_nx;
        b_nx      = (vec_nx == 16'd0) ? 32'h00000000 :
                    (vec_nx == 16'd1) ? 32'h00000001 :
                    (vec_nx == 16'd2) ? 32'hFFFFFFFF :
                    (vec_nx == 16'd3) ? 32'h7FFFFFFF : lfsr_b_nx;
`else
        lfsr_a_nx = lfsr_step(lfsr_a);
        lfsr_b_nx = lfsr_step(lfsr_b);
        a_nx      = lfsr_a_nx;
        b_nx      = lfsr_b_nx;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            lfsr_a          <= '0;
            lfsr_b          <= '0;
            misr            <= '0;
            op              <= '0;
            vec             <= '0;
            alu.ALUops      <= '0;
            alu.READ_Reg_1  <= '0;
            alu.READ_Data_2 <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state           <= RUN;
                    busy            <= 1'b1;
                    done            <= 1'b0;
                    pass            <= 1'b0;
                    lfsr_a          <= SEED_A;
                    lfsr_b          <= SEED_B;
                    misr            <= '0;
                    op              <= '0;
                    vec             <= '0;
                    alu.ALUops      <= '0;
                    alu.READ_Reg_1  <= START_A;
                    alu.READ_Data_2 <= START_B;
                end
                RUN: begin
                    misr   <= misr_nx;
                    lfsr_a <= lfsr_a_nx;
                    lfsr_b <= lfsr_b_nx;
                    op     <= op_nx;
                    vec    <= vec_nx;
                    if (last) begin
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        pass            <= (misr_nx == GOLDEN_SIG);
                        alu.ALUops      <= '0;
                        alu.READ_Reg_1  <= '0;
                        alu.READ_Data_2 <= '0;
                    end else begin
                        alu.ALUops      <= op_nx[3:0];
                        alu.READ_Reg_1  <= a_nx;
                        alu.READ_Data_2 <= b_nx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
